// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
//
// Shared definitions for the pipelined control path of the LEGv8-style core:
//   * 11-bit opcode constants (instr[31:21]) for the supported instructions
//   * ALU-control encodings driven into the EX stage
//   * instruction class enum used by the hazard unit
//   * packed per-stage control structs that travel down the pipeline
//
// No ports (package). Imported by ctrl_decode and pipe_controller.
// -----------------------------------------------------------------------------
package ctrl_pkg;

    // Opcode field width used by the constants below.
    localparam int OPC_W = 11;

    // Full 11-bit opcodes.
    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;

    // CBZ is a CB-format instruction: only the top 8 opcode bits are fixed,
    // the low 3 bits of instr[31:21] belong to the branch offset.
    localparam int                CBZ_PFX_W   = 8;
    localparam logic [CBZ_PFX_W-1:0] OPC_CBZ_PFX = 8'b10110100;

    // ALU-control encodings.
    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_ORR    = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_PASS_B = 4'b0111;

    // Instruction class seen by the hazard unit. Only classes that read a
    // second source register compare against it.
    typedef enum logic [2:0] {
        CLASS_NOP   = 3'd0,
        CLASS_RTYPE = 3'd1,
        CLASS_LOAD  = 3'd2,
        CLASS_STORE = 3'd3,
        CLASS_CBZ   = 3'd4
    } instr_class_e;

    // EX-stage controls.
    typedef struct packed {
        logic [3:0] aluctl;
        logic       alusrc;
    } ex_ctrl_t;

    // MEM-stage controls.
    typedef struct packed {
        logic branch;
        logic memread;
        logic memwrite;
    } mem_ctrl_t;

    // WB-stage controls.
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    // Everything the ID/EX register carries for the later stages.
    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } stage_ctrl_t;

    // What the EX/MEM register carries.
    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } exmem_ctrl_t;

    // Full decoder output: reg2loc is consumed in ID only and never latched.
    typedef struct packed {
        logic        reg2loc;
        stage_ctrl_t stage;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // True for classes whose second register read feeds a datapath operand.
    function automatic logic reads_src2(input instr_class_e c);
        return (c == CLASS_RTYPE) || (c == CLASS_STORE) || (c == CLASS_CBZ);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
//
// Purely combinational main decoder: maps the ID-stage opcode field to the
// full set of pipeline control bits plus an instruction class for the hazard
// unit. Unrecognised opcodes (including all-zero) decode as a NOP with every
// control bit cleared.
//
// Ports
//   opcode  in   OP_W   instr[31:21] of the instruction in ID
//   ctrl    out  ctrl_t decoded control bits
//   iclass  out  enum   instruction class
// -----------------------------------------------------------------------------
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 11
) (
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl,
    output instr_class_e    iclass
);

    always_comb begin
        ctrl   = CTRL_NOP;
        iclass = CLASS_NOP;

        // CBZ is matched on its fixed prefix before the full-opcode compares.
        if (opcode[OP_W-1 -: CBZ_PFX_W] == OPC_CBZ_PFX) begin
            iclass                   = CLASS_CBZ;
            ctrl.reg2loc             = 1'b1;
            ctrl.stage.mem.branch    = 1'b1;
            ctrl.stage.ex.aluctl     = ALU_PASS_B;
        end else if (opcode == OP_W'(OPC_ADD)) begin
            iclass                   = CLASS_RTYPE;
            ctrl.stage.wb.regwrite   = 1'b1;
            ctrl.stage.ex.aluctl     = ALU_ADD;
        end else if (opcode == OP_W'(OPC_SUB)) begin
            iclass                   = CLASS_RTYPE;
            ctrl.stage.wb.regwrite   = 1'b1;
            ctrl.stage.ex.aluctl     = ALU_SUB;
        end else if (opcode == OP_W'(OPC_AND)) begin
            iclass                   = CLASS_RTYPE;
            ctrl.stage.wb.regwrite   = 1'b1;
            ctrl.stage.ex.aluctl     = ALU_AND;
        end else if (opcode == OP_W'(OPC_ORR)) begin
            iclass                   = CLASS_RTYPE;
            ctrl.stage.wb.regwrite   = 1'b1;
            ctrl.stage.ex.aluctl     = ALU_ORR;
        end else if (opcode == OP_W'(OPC_LDUR)) begin
            iclass                   = CLASS_LOAD;
            ctrl.stage.ex.alusrc     = 1'b1;
            ctrl.stage.mem.memread   = 1'b1;
            ctrl.stage.wb.memtoreg   = 1'b1;
            ctrl.stage.wb.regwrite   = 1'b1;
            ctrl.stage.ex.aluctl     = ALU_ADD;
        end else if (opcode == OP_W'(OPC_STUR)) begin
            iclass                   = CLASS_STORE;
            ctrl.reg2loc             = 1'b1;
            ctrl.stage.ex.alusrc     = 1'b1;
            ctrl.stage.mem.memwrite  = 1'b1;
            ctrl.stage.ex.aluctl     = ALU_ADD;
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// -----------------------------------------------------------------------------
// pipe_controller
//
// Control path of a 5-stage pipeline. Decodes the instruction in ID, carries
// its control bits through the ID/EX, EX/MEM and MEM/WB registers, detects
// load-use hazards and squashes younger work when a branch resolves taken in
// MEM.
//
// Ports
//   clk               in   1         rising-edge clock
//   reset             in   1         asynchronous, active-high reset
//   instr_id          in   32        instruction in ID
//   branch_taken_mem  in   1         branch in MEM resolved taken
//   id_reg2loc        out  1         ID read-port-2 select (combinational)
//   stall             out  1         hold PC and IF/ID (combinational)
//   flush             out  1         squash IF/ID (combinational)
//   ex_aluctl         out  ALUCTL_W  EX ALU control (registered)
//   ex_alusrc         out  1         EX ALU operand-B select (registered)
//   mem_branch        out  1         MEM branch (registered)
//   mem_read          out  1         MEM read enable (registered)
//   mem_write         out  1         MEM write enable (registered)
//   wb_regwrite       out  1         WB register write (registered)
//   wb_memtoreg       out  1         WB result select (registered)
// -----------------------------------------------------------------------------
module pipe_controller
    import ctrl_pkg::*;
#(
    parameter int OP_W     = 11,
    parameter int ALUCTL_W = 4,
    parameter int RA_W     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr_id,
    input  logic                branch_taken_mem,
    output logic                id_reg2loc,
    output logic                stall,
    output logic                flush,
    output logic [ALUCTL_W-1:0] ex_aluctl,
    output logic                ex_alusrc,
    output logic                mem_branch,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_regwrite,
    output logic                wb_memtoreg
);

    // The all-ones register is the zero register; writes to it are dropped,
    // so it can never be the source of a real dependency.
    localparam logic [RA_W-1:0] XZR = '1;

    // ---------------------------------------------------------------- ID stage
    logic [OP_W-1:0] id_opcode;
    logic [RA_W-1:0] id_rn;
    logic [RA_W-1:0] id_rm;
    logic [RA_W-1:0] id_rd;
    logic [RA_W-1:0] id_src2;
    ctrl_t           id_ctrl;
    instr_class_e    id_class;

    assign id_opcode = instr_id[31 -: OP_W];
    assign id_rn     = instr_id[5  +: RA_W];
    assign id_rm     = instr_id[16 +: RA_W];
    assign id_rd     = instr_id[0  +: RA_W];

    // Only the register fields and opcode are decoded here; the remaining
    // bits (shamt, immediates) belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_id;

    ctrl_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .opcode (id_opcode),
        .ctrl   (id_ctrl),
        .iclass (id_class)
    );

    assign id_reg2loc = id_ctrl.reg2loc;

    // Second read port address follows reg2loc: STUR/CBZ read Rt in [4:0].
    assign id_src2 = id_ctrl.reg2loc ? id_rd : id_rm;

    // --------------------------------------------------------- pipeline state
    stage_ctrl_t     id_ex_q,  id_ex_d;
    logic [RA_W-1:0] ex_rd_q,  ex_rd_d;
    exmem_ctrl_t     ex_mem_q, ex_mem_d;
    wb_ctrl_t        mem_wb_q, mem_wb_d;

    // ------------------------------------------------------------ hazard unit
    // A load in EX whose destination is read by the instruction in ID cannot
    // forward in time; hold ID one cycle and send a bubble into EX. The
    // bubble clears EX memread, so the stall lasts exactly one cycle.
    logic load_use;

    always_comb begin
        load_use = 1'b0;
        if (id_ex_q.mem.memread && (ex_rd_q != XZR)) begin
            if (ex_rd_q == id_rn) begin
                load_use = 1'b1;
            end else if (reads_src2(id_class) && (ex_rd_q == id_src2)) begin
                load_use = 1'b1;
            end
        end
    end

    // A taken branch wipes everything younger than itself, including the
    // instruction that would have stalled, so flush wins over stall.
    assign flush = branch_taken_mem;
    assign stall = load_use && !branch_taken_mem;

    // ------------------------------------------------------- next-state logic
    always_comb begin
        id_ex_d      = id_ctrl.stage;
        ex_rd_d      = id_rd;
        if (flush || stall) begin
            id_ex_d = '0;
        end

        ex_mem_d.mem = id_ex_q.mem;
        ex_mem_d.wb  = id_ex_q.wb;
        if (flush) begin
            ex_mem_d = '0;
        end

        // The branch itself moves on to WB; its WB controls are all zero.
        mem_wb_d     = ex_mem_q.wb;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_q  <= '0;
            ex_rd_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_rd_q  <= ex_rd_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign ex_aluctl   = ALUCTL_W'(id_ex_q.ex.aluctl);
    assign ex_alusrc   = id_ex_q.ex.alusrc;
    assign mem_branch  = ex_mem_q.mem.branch;
    assign mem_read    = ex_mem_q.mem.memread;
    assign mem_write   = ex_mem_q.mem.memwrite;
    assign wb_regwrite = mem_wb_q.regwrite;
    assign wb_memtoreg = mem_wb_q.memtoreg;

endmodule

// File: tb/tb_pipe_controller.sv
// -----------------------------------------------------------------------------
// tb_pipe_controller
//
// Directed, table-driven bench for pipe_controller. Each table row is one
// clock cycle: the instruction and branch flag driven into ID/MEM, and the
// 13-bit output vector expected in that same cycle:
//   {id_reg2loc, stall, flush, ex_aluctl[3:0], ex_alusrc,
//    mem_branch, mem_read, mem_write, wb_regwrite, wb_memtoreg}
// Hand-written sequences cover reset and asynchronous reset mid-pipeline.
// -----------------------------------------------------------------------------
module tb_pipe_controller;

  localparam int W = 13;

  localparam logic [10:0] OP_NOP  = 11'b00000000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;

  // ---------------------------------------------------------- clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_id = '0;
  logic        branch_taken_mem = 1'b0;

  logic       id_reg2loc, stall, flush;
  logic [3:0] ex_aluctl;
  logic       ex_alusrc, mem_branch, mem_read, mem_write;
  logic       wb_regwrite, wb_memtoreg;

  always #5 clk = ~clk;

  pipe_controller dut (
    .clk              (clk),
    .reset            (reset),
    .instr_id         (instr_id),
    .branch_taken_mem (branch_taken_mem),
    .id_reg2loc       (id_reg2loc),
    .stall            (stall),
    .flush            (flush),
    .ex_aluctl        (ex_aluctl),
    .ex_alusrc        (ex_alusrc),
    .mem_branch       (mem_branch),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .wb_regwrite      (wb_regwrite),
    .wb_memtoreg      (wb_memtoreg)
  );

  // -------------------------------------------------------------- helpers
  function automatic logic [31:0] ins(input logic [10:0] op, input logic [4:0] rm,
                                      input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'b000000, rn, rd};
  endfunction

  function automatic logic [W-1:0] e(input logic r2l, input logic st, input logic fl,
                                     input logic [3:0] alu, input logic asrc,
                                     input logic br, input logic mr, input logic mw,
                                     input logic rw, input logic mtr);
    return {r2l, st, fl, alu, asrc, br, mr, mw, rw, mtr};
  endfunction

  function automatic logic [W-1:0] observed();
    return {id_reg2loc, stall, flush, ex_aluctl, ex_alusrc,
            mem_branch, mem_read, mem_write, wb_regwrite, wb_memtoreg};
  endfunction

  // ------------------------------------------------------------ scoreboard
  int unsigned    checks = 0;
  int unsigned    errors = 0;
  logic [W-1:0]   exp_q[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (r2l,st,fl,alu,asrc,br,mr,mw,rw,mtr)",
               name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  typedef struct {
    logic [31:0] instr;
    logic        br;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] instr, input logic br, input logic [W-1:0] exp);
    vec_t v;
    v.instr = instr;
    v.br    = br;
    vecs.push_back(v);
    exp_q.push_back(exp);
  endtask

  // Drive one cycle's inputs after the falling edge and sample shortly after.
  task automatic drive(input logic [31:0] instr, input logic br);
    @(negedge clk);
    instr_id         = instr;
    branch_taken_mem = br;
    #1;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [31:0] nop;
    nop = ins(OP_NOP, 5'd0, 5'd0, 5'd0);

    // ADD X1,X2,X3 followed by NOPs
    add(ins(OP_ADD, 5'd3, 5'd2, 5'd1), 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0010,0,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,1,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    // SUB, STUR, CBZ (not taken), AND, ORR through every stage
    add(ins(OP_SUB,  5'd6, 5'd5, 5'd4), 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(ins(OP_STUR, 5'd0, 5'd8, 5'd7), 1'b0, e(1,0,0,4'b0110,0,0,0,0,0,0));
    add(ins(OP_CBZ,  5'd0, 5'd0, 5'd9), 1'b0, e(1,0,0,4'b0010,1,0,0,0,0,0));
    add(ins(OP_AND,  5'd3, 5'd2, 5'd1), 1'b0, e(0,0,0,4'b0111,0,0,0,1,1,0));
    add(ins(OP_ORR,  5'd3, 5'd2, 5'd1), 1'b0, e(0,0,0,4'b0000,0,1,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0001,0,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,1,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,1,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    // LDUR X5,[X2]; ADD X6,X5,X7 -> one stall, bubble, ADD held in ID
    add(ins(OP_LDUR, 5'd0, 5'd2, 5'd5), 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(ins(OP_ADD,  5'd7, 5'd5, 5'd6), 1'b0, e(0,1,0,4'b0010,1,0,0,0,0,0));
    add(ins(OP_ADD,  5'd7, 5'd5, 5'd6), 1'b0, e(0,0,0,4'b0000,0,0,1,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0010,0,0,0,0,1,1));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,1,0));
    // LDUR X31,[X2]; ADD X6,X31,X7 -> no stall on the zero register
    add(ins(OP_LDUR, 5'd0,  5'd2,  5'd31), 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(ins(OP_ADD,  5'd7,  5'd31, 5'd6),  1'b0, e(0,0,0,4'b0010,1,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0010,0,0,1,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,1,1));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,1,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    // STUR after LDUR X5: bits[20:16]=5 but reg2loc selects Rt=9 -> no stall.
    // Then LDUR X5 followed by SUB X6,X7,X5 -> stall through the Rm path.
    add(ins(OP_LDUR, 5'd0, 5'd2,  5'd5), 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(ins(OP_STUR, 5'd5, 5'd10, 5'd9), 1'b0, e(1,0,0,4'b0010,1,0,0,0,0,0));
    add(ins(OP_LDUR, 5'd0, 5'd2,  5'd5), 1'b0, e(0,0,0,4'b0010,1,0,1,0,0,0));
    add(ins(OP_SUB,  5'd5, 5'd7,  5'd6), 1'b0, e(0,1,0,4'b0010,1,0,0,1,1,1));
    add(ins(OP_SUB,  5'd5, 5'd7,  5'd6), 1'b0, e(0,0,0,4'b0000,0,0,1,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0110,0,0,0,0,1,1));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,1,0));
    // CBZ taken in MEM while LDUR X5 is in EX and dependent ADD is in ID:
    // flush wins over stall, younger controls vanish.
    add(ins(OP_CBZ,  5'd0, 5'd0, 5'd1), 1'b0, e(1,0,0,4'b0000,0,0,0,0,0,0));
    add(ins(OP_LDUR, 5'd0, 5'd2, 5'd5), 1'b0, e(0,0,0,4'b0111,0,0,0,0,0,0));
    add(ins(OP_ADD,  5'd7, 5'd5, 5'd6), 1'b1, e(0,0,1,4'b0010,1,1,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));
    add(nop, 1'b0, e(0,0,0,4'b0000,0,0,0,0,0,0));

    // Reset state: outputs all zero while reset is held.
    instr_id = nop;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_state", observed(), e(0,0,0,4'b0000,0,0,0,0,0,0));
    reset = 1'b0;

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      logic [W-1:0] exp;
      drive(vecs[i].instr, vecs[i].br);
      exp = exp_q.pop_front();
      check($sformatf("row%0d", i), observed(), exp);
    end

    // Asynchronous reset in the middle of a loaded pipeline.
    drive(ins(OP_ADD,  5'd3, 5'd2, 5'd1), 1'b0);
    drive(ins(OP_LDUR, 5'd0, 5'd2, 5'd5), 1'b0);
    drive(ins(OP_ADD,  5'd7, 5'd5, 5'd6), 1'b0);
    check("pre_reset_stall", observed(), e(0,1,0,4'b0010,1,0,0,0,0,0));
    drive(ins(OP_ADD,  5'd7, 5'd5, 5'd6), 1'b0);
    check("pre_reset_full", observed(), e(0,0,0,4'b0000,0,0,1,0,1,0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", observed(), e(0,0,0,4'b0000,0,0,0,0,0,0));
    drive(ins(OP_ADD,  5'd7, 5'd5, 5'd6), 1'b0);
    check("reset_held", observed(), e(0,0,0,4'b0000,0,0,0,0,0,0));
    // Release with SUB in ID: it reaches EX after the first edge out of reset.
    @(negedge clk);
    reset    = 1'b0;
    instr_id = ins(OP_SUB, 5'd3, 5'd2, 5'd1);
    drive(nop, 1'b0);
    check("post_reset_ex", observed(), e(0,0,0,4'b0110,0,0,0,0,0,0));
    drive(nop, 1'b0);
    check("post_reset_mem", observed(), e(0,0,0,4'b0000,0,0,0,0,0,0));
    drive(nop, 1'b0);
    check("post_reset_wb", observed(), e(0,0,0,4'b0000,0,0,0,0,1,0));
    drive(nop, 1'b0);
    check("post_reset_idle", observed(), e(0,0,0,4'b0000,0,0,0,0,0,0));

    // ---------------------------------------------------------- report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have parameter OP_W, default 11, meaning opcode field width (instr[31:21]).
REQ-002 SHALL have parameter ALUCTL_W, default 4, meaning ALU control width.
REQ-003 SHALL have parameter RA_W, default 5, meaning register-address width; register 2**RA_W-1 (XZR) never creates a hazard.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port instr_id  in  32  instruction currently in ID stage.
REQ-007 SHALL have port branch_taken_mem  in  1  branch resolved taken in MEM (Branch & zero).
REQ-008 SHALL have port id_reg2loc  out  1  ID-stage read-port-2 select, combinational from instr_id.
REQ-009 SHALL have port stall  out  1  hold PC and IF/ID; combinational.
REQ-010 SHALL have port flush  out  1  squash IF/ID; combinational, equals branch_taken_mem.
REQ-011 SHALL have ports ex_aluctl (ALUCTL_W), ex_alusrc (1)  out  EX-stage controls, registered.
REQ-012 SHALL have ports mem_branch, mem_read, mem_write  out  1 each  MEM-stage controls, registered.
REQ-013 SHALL have ports wb_regwrite, wb_memtoreg  out  1 each  WB-stage controls, registered.

Function
REQ-014 Decode SHALL map: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> R-type (regwrite, aluctl 0010/0110/0000/0001); LDUR 11111000010 -> alusrc, memread, memtoreg, regwrite, aluctl 0010; STUR 11111000000 -> alusrc, memwrite, reg2loc, aluctl 0010; CBZ 10110100xxx -> branch, reg2loc, aluctl 0111.
REQ-015 Any other opcode, including all-zero, SHALL decode to all control bits 0 (NOP).
REQ-016 Controls SHALL advance ID->EX->MEM->WB one stage per clock: EX outputs valid 1 cycle, MEM 2 cycles, WB 3 cycles after instr_id is sampled.
REQ-017 ID/EX register SHALL also hold destination rd = instr[4:0] and memread of the decoded instruction.
REQ-018 Load-use hazard: stall SHALL be 1 when EX memread=1, EX rd != XZR, and EX rd equals instr_id[9:5], or equals the source-2 register (instr[4:0] if id_reg2loc else instr[20:16]) for R-type, STUR, CBZ.
REQ-019 While stall=1 the ID/EX register SHALL load all-zero controls (bubble); EX/MEM and MEM/WB SHALL advance normally.
REQ-020 A stall SHALL last exactly one cycle per load-use pair, as the bubble clears EX memread.
REQ-021 When branch_taken_mem=1, next edge SHALL zero ID/EX and EX/MEM controls; MEM/WB SHALL capture the branch's own (harmless) controls.
REQ-022 Flush SHALL take priority over stall: with both conditions active, stall SHALL be 0 and flush behaviour applies.
REQ-023 Branch instruction in MEM with branch_taken_mem=0 SHALL cause no squash.

Reset
REQ-024 reset=1 SHALL asynchronously clear all pipeline registers; every registered output SHALL read 0 and stall SHALL read 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight controls; first valid EX output appears 1 cycle after the first edge with reset=0.

Structure
REQ-026 A shared package ctrl_pkg SHALL hold opcode constants, ALU-control encodings, and a packed struct of per-stage control bits.
REQ-027 Decode SHALL be a combinational sub-module ctrl_decode (opcode -> control struct); pipeline and hazard logic stay in pipe_controller.

Verification
REQ-028 ADD X1,X2,X3 then 3 NOPs -> ex_aluctl=0010 at cycle 1, wb_regwrite=1 at cycle 3, all else 0.
REQ-029 LDUR X5,[X2] followed by ADD X6,X5,X7 -> stall=1 for one cycle, next EX controls all 0, ADD reaches EX one cycle later.
REQ-030 LDUR X31,[X2] followed by ADD X6,X31,X7 -> stall never asserted.
REQ-031 CBZ in MEM with branch_taken_mem=1 while LDUR/ADD follow -> ID/EX and EX/MEM controls 0 after edge; flush=1 same cycle; no later mem_write/regwrite from squashed ops.
REQ-032 Load-use condition and branch_taken_mem=1 same cycle -> stall=0, flush=1.
REQ-033 Reset pulsed asynchronously between edges during a full pipeline -> all outputs 0 immediately, no stale wb_regwrite after release.
